// File: rtl/lsu.sv
// lsu: load/store unit with valid/ready word bus; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic [2:0]        memsize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_d;
  logic op_we, start, legal, bad;
  logic [2:0] op_size;
  logic [1:0] a_lo;
  logic [3:0] be_d;
  logic [31:0] wd_d, ext;
  logic [7:0] rb;
  logic [15:0] rh;
  logic sg;
  assign start = memwrite | memtoreg;
  assign legal = (memsize[1:0] != 2'b11) && (memwrite ? !memsize[2] : memsize != 3'b110);
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = !legal || (memsize[1:0] == 2'b01 && addr[0]) || (memsize[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
  assign bad = !legal;
`endif
  always_comb begin
    state_d = state == IDLE ? (start ? (bad ? DONE : REQ) : IDLE) :
              state == REQ  ? (bus_ready ? (op_we ? DONE : WAIT) : REQ) :
              state == WAIT ? (bus_rvalid ? DONE : WAIT) : IDLE;
    stall = state == IDLE ? start : state != DONE;
    done = state == DONE;
  end
  always_comb begin
    be_d = memsize[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
           memsize[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_d = memsize[1:0] == 2'b00 ? {4{wdata[7:0]}} :
           memsize[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rb = bus_rdata[{a_lo, 3'b000} +: 8];
    rh = a_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    sg = !op_size[2];
    ext = op_size[1:0] == 2'b00 ? {{24{sg & rb[7]}}, rb} :
          op_size[1:0] == 2'b01 ? {{16{sg & rh[15]}}, rh} : bus_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_we <= 1'b0;
      op_size <= 3'b000;
      a_lo <= 2'b00;
      err <= 1'b0;
      rdata <= '0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        op_we <= memwrite;
        op_size <= memsize;
        a_lo <= addr[1:0];
        err <= bad;
        if (bad) rdata <= '0;
        else begin
          bus_req <= 1'b1;
          bus_we <= memwrite;
          bus_addr <= {addr[ADDR_W-1:2], 2'b00};
          bus_be <= be_d;
          bus_wdata <= wd_d;
        end
      end
      if (state == REQ && bus_ready) begin
        bus_req <= 1'b0;
        if (op_we) rdata <= '0;
      end
      if (state == WAIT && bus_rvalid) rdata <= ext;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed load/store vectors against hand-computed results
module tb_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic memwrite = 1'b0, memtoreg = 1'b0;
  logic [2:0] memsize = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic stall, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .memtoreg(memtoreg),
    .memsize(memsize), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_be"}, {28'd0, bus_be}, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
  endtask
  task automatic run(input string tag, input logic we, input logic rd, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                     input int rdy_at, input int rv_at, input int exp_done, input int exp_req,
                     input logic exp_err, input logic [31:0] exp_rd, input logic [31:0] exp_addr,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int stalls, reqs, dc;
    logic stable, got_err, cap_we;
    logic [31:0] got_rd, cap_a, cap_wd;
    logic [3:0] cap_be;
    stalls = 0; reqs = 0; dc = -1; stable = 1'b1; got_err = 1'bx; got_rd = 'x;
    cap_we = 1'bx; cap_a = 'x; cap_wd = 'x; cap_be = 'x;
    @(posedge clk); #1;
    memwrite = we; memtoreg = rd; memsize = sz; addr = a; wdata = wd; bus_rdata = word;
    for (int c = 0; c < 40 && dc < 0; c++) begin
      @(negedge clk);
      stalls += int'(stall);
      if (bus_req) begin
        if (reqs == 0) begin
          cap_we = bus_we; cap_a = bus_addr; cap_be = bus_be; cap_wd = bus_wdata;
        end else if ({cap_we, cap_a, cap_be, cap_wd} !== {bus_we, bus_addr, bus_be, bus_wdata})
          stable = 1'b0;
        reqs++;
      end
      if (done) begin
        dc = c; got_rd = rdata; got_err = err;
      end
      bus_ready = c >= rdy_at;
      bus_rvalid = c >= rv_at;
    end
    memwrite = 1'b0; memtoreg = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
    chk({tag, "_done_cycle"}, dc, exp_done);
    chk({tag, "_stall_cycles"}, stalls, exp_done);
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, got_rd, exp_rd);
    chk({tag, "_req_cycles"}, reqs, exp_req);
    if (exp_req > 0) begin
      chk({tag, "_bus_we"}, {31'd0, cap_we}, {31'd0, we});
      chk({tag, "_bus_addr"}, cap_a, exp_addr);
      chk({tag, "_bus_be"}, {28'd0, cap_be}, {28'd0, exp_be});
      chk({tag, "_bus_wdata"}, cap_wd, exp_wd);
      chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
    end
  endtask
  initial begin
    logic saw_done;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    run("sb",   1, 0, 3'b000, 32'h203, 32'h000000A5, 32'h0,        1, 99, 2, 1, 0, 32'h0,        32'h200, 4'b1000, 32'hA5A5A5A5);
    run("lb",   0, 1, 3'b000, 32'h203, 32'h0,        32'hA5000000, 1, 2,  3, 1, 0, 32'hFFFFFFA5, 32'h200, 4'b1000, 32'h0);
    run("lbu",  0, 1, 3'b100, 32'h203, 32'h0,        32'hA5000000, 1, 2,  3, 1, 0, 32'h000000A5, 32'h200, 4'b1000, 32'h0);
    run("sw",   1, 0, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        1, 1,  2, 1, 0, 32'h0,        32'h104, 4'b1111, 32'hDEADBEEF);
    run("lh",   0, 1, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 1, 2,  3, 1, 0, 32'hFFFF8001, 32'h100, 4'b1100, 32'h0);
    run("lhu",  0, 1, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 1, 2,  3, 1, 0, 32'h00008001, 32'h100, 4'b1100, 32'h0);
    run("sh",   1, 0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1, 99, 2, 1, 0, 32'h0,        32'h200, 4'b1100, 32'hABCDABCD);
    run("lbpos",0, 1, 3'b000, 32'h201, 32'h0,        32'h00007F00, 1, 2,  3, 1, 0, 32'h0000007F, 32'h200, 4'b0010, 32'h0);
    run("lwslow",0,1, 3'b010, 32'h100, 32'h0,        32'h12345678, 3, 5,  6, 3, 0, 32'h12345678, 32'h100, 4'b1111, 32'h0);
    run("both", 1, 1, 3'b010, 32'h300, 32'h11223344, 32'h0,        1, 99, 2, 1, 0, 32'h0,        32'h300, 4'b1111, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    run("lwmis",0, 1, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 1, 2,  1, 0, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
`else
    run("lwmis",0, 1, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 1, 2,  3, 1, 0, 32'hCAFEF00D, 32'h100, 4'b1111, 32'h0);
`endif
    run("ld011",0, 1, 3'b011, 32'h100, 32'h0,        32'h0,        1, 2,  1, 0, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
    run("st100",1, 0, 3'b100, 32'h100, 32'hFF,       32'h0,        1, 2,  1, 0, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
    @(posedge clk); #1;
    memtoreg = 1'b1; memsize = 3'b010; addr = 32'h400; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstreq_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0; memtoreg = 1'b0;
    #1 chk("rstreq_drop", {31'd0, bus_req}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    memtoreg = 1'b1; memsize = 3'b010; addr = 32'h400; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    @(negedge clk); bus_ready = 1'b1;
    @(negedge clk);
    chk("rstwait_stall", {31'd0, stall}, 32'd1);
    chk("rstwait_req", {31'd0, bus_req}, 32'd0);
    rst_n = 1'b0; memtoreg = 1'b0; bus_ready = 1'b0;
    #1 chk_idle("rstwait_in");
    bus_rvalid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_done |= done;
      bus_rvalid = i < 2;
    end
    chk("rstwait_no_done", {31'd0, saw_done}, 32'd0);
    chk_idle("rstwait_after");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
